// File: rtl/jtbubl_sndcomm.sv
// ---------------------------------------------------------------------------
// jtbubl_sndcomm
//
// Command/reply mailbox between the main CPU and the sound CPU, plus the
// sound CPU reset sequencer and NMI generation.
//
// Parameters
//   RSTLEN : clk24 cycles of STRETCH after the reset request is released.
//   NMIGAP : clk24 cycles the NMI is held off after each command read.
//
// Ports
//   clk24       in   single clock, everything changes on its rising edge
//   rst         in   synchronous active-high reset
//   main_wr     in   strobe: main CPU wrote main_latch into the command byte
//   main_latch  in   command byte (valid with main_wr)
//   main_rd     in   strobe: main CPU consumed the reply byte
//   snd_rst_in  in   level: main board requests sound CPU reset
//   snd_reply   out  reply byte for the main CPU
//   reply_pend  out  reply written and not yet consumed
//   snd_cs      in   strobe: sound CPU register access
//   snd_rnw     in   1 = read, 0 = write
//   snd_addr    in   0 = data register, 1 = control/status register
//   snd_din     in   sound CPU write data
//   snd_dout    out  sound CPU read data (combinational)
//   snd_nmi_n   out  NMI to sound CPU, active low level
//   snd_rst_n   out  reset to sound CPU, active low
//   overrun     out  sticky: a command was overwritten before being read
// ---------------------------------------------------------------------------
module jtbubl_sndcomm #(
    parameter int RSTLEN = 16,
    parameter int NMIGAP = 4
) (
    input  logic       clk24,
    input  logic       rst,
    input  logic       main_wr,
    input  logic [7:0] main_latch,
    input  logic       main_rd,
    input  logic       snd_rst_in,
    output logic [7:0] snd_reply,
    output logic       reply_pend,
    input  logic       snd_cs,
    input  logic       snd_rnw,
    input  logic       snd_addr,
    input  logic [7:0] snd_din,
    output logic [7:0] snd_dout,
    output logic       snd_nmi_n,
    output logic       snd_rst_n,
    output logic       overrun
);

    localparam int RW = $clog2(RSTLEN) + 1;
    localparam int GW = $clog2(NMIGAP) + 1;

    localparam logic [RW-1:0] RST_LOAD = RW'(RSTLEN - 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'(NMIGAP);

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_HOLD    = 2'd1;
    localparam logic [1:0] ST_STRETCH = 2'd2;

    logic [1:0]    state_q,      state_d;
    logic [RW-1:0] rst_cnt_q,    rst_cnt_d;
    logic [7:0]    cmd_q,        cmd_d;
    logic          cmd_pend_q,   cmd_pend_d;
    logic [7:0]    reply_q,      reply_d;
    logic          reply_pend_q, reply_pend_d;
    logic          nmi_en_q,     nmi_en_d;
    logic          overrun_q,    overrun_d;
    logic [GW-1:0] gap_cnt_q,    gap_cnt_d;

    logic run_now_s;
    logic run_next_s;
    logic rd0_s;
    logic wr0_s;
    logic wr1_s;

    // Reset sequencer: hold while requested, then stretch RSTLEN cycles.
    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (snd_rst_in) begin
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_HOLD: begin
                if (snd_rst_in) begin
                    state_d = ST_HOLD;
                end else begin
                    state_d   = ST_STRETCH;
                    rst_cnt_d = RST_LOAD;
                end
            end
            ST_STRETCH: begin
                if (snd_rst_in) begin
                    state_d = ST_HOLD;
                end else if (rst_cnt_q == {RW{1'b0}}) begin
                    state_d = ST_RUN;
                end else begin
                    rst_cnt_d = rst_cnt_q - RW'(1);
                end
            end
            default: begin
                state_d = ST_HOLD;
            end
        endcase
    end

    // Sound CPU accesses only count while it is out of reset.
    always_comb begin
        run_now_s  = (state_q == ST_RUN);
        run_next_s = (state_d == ST_RUN);
        rd0_s      = run_now_s & snd_cs &  snd_rnw & ~snd_addr;
        wr0_s      = run_now_s & snd_cs & ~snd_rnw & ~snd_addr;
        wr1_s      = run_now_s & snd_cs & ~snd_rnw &  snd_addr;
    end

    // Mailbox next-state. Flags tied to the sound CPU are forced clear
    // whenever it will be in reset after this edge; a command arriving on
    // the very edge that releases reset is still accepted.
    always_comb begin
        if (main_wr && (run_now_s || run_next_s)) begin
            cmd_d = main_latch;
        end else begin
            cmd_d = cmd_q;
        end

        if (!run_next_s) begin
            cmd_pend_d = 1'b0;
        end else if (main_wr) begin
            cmd_pend_d = 1'b1;
        end else if (rd0_s) begin
            cmd_pend_d = 1'b0;
        end else begin
            cmd_pend_d = cmd_pend_q;
        end

        // A same-cycle read consumes the old byte, so that is not an overrun.
        if (main_wr && run_now_s && cmd_pend_q && !rd0_s) begin
            overrun_d = 1'b1;
        end else if (wr1_s && snd_din[1]) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end

        if (!run_next_s) begin
            nmi_en_d = 1'b0;
        end else if (wr1_s) begin
            nmi_en_d = snd_din[0];
        end else begin
            nmi_en_d = nmi_en_q;
        end

        // Hold-off after each read forces a fresh NMI falling edge.
        if (!run_next_s) begin
            gap_cnt_d = {GW{1'b0}};
        end else if (rd0_s) begin
            gap_cnt_d = GAP_LOAD;
        end else if (gap_cnt_q != {GW{1'b0}}) begin
            gap_cnt_d = gap_cnt_q - GW'(1);
        end else begin
            gap_cnt_d = gap_cnt_q;
        end

        if (wr0_s) begin
            reply_d      = snd_din;
            reply_pend_d = 1'b1;
        end else if (main_rd) begin
            reply_d      = reply_q;
            reply_pend_d = 1'b0;
        end else begin
            reply_d      = reply_q;
            reply_pend_d = reply_pend_q;
        end
    end

    // State registers with synchronous reset taking priority over all strobes.
    always_ff @(posedge clk24) begin
        if (rst) begin
            state_q      <= ST_HOLD;
            rst_cnt_q    <= {RW{1'b0}};
            cmd_q        <= 8'h00;
            cmd_pend_q   <= 1'b0;
            reply_q      <= 8'h00;
            reply_pend_q <= 1'b0;
            nmi_en_q     <= 1'b0;
            overrun_q    <= 1'b0;
            gap_cnt_q    <= {GW{1'b0}};
        end else begin
            state_q      <= state_d;
            rst_cnt_q    <= rst_cnt_d;
            cmd_q        <= cmd_d;
            cmd_pend_q   <= cmd_pend_d;
            reply_q      <= reply_d;
            reply_pend_q <= reply_pend_d;
            nmi_en_q     <= nmi_en_d;
            overrun_q    <= overrun_d;
            gap_cnt_q    <= gap_cnt_d;
        end
    end

    // Sound CPU read mux.
    always_comb begin
        if (snd_addr) begin
            snd_dout = {4'b0000, overrun_q, nmi_en_q, reply_pend_q, cmd_pend_q};
        end else begin
            snd_dout = cmd_q;
        end
    end

    assign snd_reply  = reply_q;
    assign reply_pend = reply_pend_q;
    assign overrun    = overrun_q;
    assign snd_rst_n  = (state_q == ST_RUN);
    assign snd_nmi_n  = ~(cmd_pend_q & nmi_en_q & (gap_cnt_q == {GW{1'b0}}));

endmodule
